fb_div_ctrl: RTL

- Programmable PLL feedback divider with a ratio-switch sequencer; produces clk_fb from clk at ratio N.
- Odd N gives 50% duty via posedge/negedge half-cycle stretch; even N uses the posedge path only.
- Ratio changes arrive over a valid/ready config handshake and are applied only at an output-period boundary, so clk_fb never glitches.
- A settle window follows each change before cfg_done is reported to the PLL lock logic.

---
 rtl/fb_div_pkg.sv | 13 +
 rtl/fb_div_ctrl_if.sv | 29 ++
 rtl/fb_div_core.sv | 54 +++++
 rtl/fb_div_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fb_div_pkg.sv
// fb_div_pkg: shared types and constants for the PLL
// feedback divider and its ratio-switch sequencer.
package fb_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WRAP,
        SETTLE
    } fb_div_state_e;

    localparam int MIN_N = 2;

endpackage

// File: rtl/fb_div_ctrl_if.sv
// fb_div_ctrl_if: ratio configuration handshake between the
// PLL lock logic (master) and the feedback divider (slave).
interface fb_div_ctrl_if #(
    parameter int W = 4
);

    logic         cfg_valid;
    logic [W-1:0] cfg_ratio;
    logic         cfg_ready;
    logic         cfg_done;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ratio,
        input  cfg_ready,
        input  cfg_done,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ratio,
        output cfg_ready,
        output cfg_done,
        output cfg_err
    );

endinterface

// File: rtl/fb_div_core.sv
// fb_div_core: dual-edge divide-by-N counter with 50% duty
// decode; odd ratios stretch the high phase by half a cycle.
module fb_div_core
    import fb_div_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic [W-1:0] ratio,
    output logic         terminal,
    output logic         clk_fb
);

    logic [W-1:0] cnt_pos_q;
    logic [W-1:0] cnt_pos_d;
    logic [W-1:0] cnt_neg_q;
    logic [W-1:0] half;
    logic         pos_hi;
    logic         neg_hi;

    assign half     = ratio >> 1;
    assign terminal = run & (cnt_pos_q == ratio - W'(1));

    always_comb begin
        cnt_pos_d = cnt_pos_q + W'(1);
        if (!run || terminal) begin
            cnt_pos_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_pos_q <= '0;
        end else begin
            cnt_pos_q <= cnt_pos_d;
        end
    end

    // Half-cycle delayed copy keeps both edges on the same ratio.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_neg_q <= '0;
        end else begin
            cnt_neg_q <= cnt_pos_q;
        end
    end

    assign pos_hi = run & (cnt_pos_q < half);
    assign neg_hi = run & ratio[0] & (cnt_neg_q < half);
    assign clk_fb = pos_hi | neg_hi;

endmodule

// File: rtl/fb_div_ctrl.sv
// fb_div_ctrl: feedback divider top; applies new ratios only at
// an output-period boundary and reports settling to lock logic.
module fb_div_ctrl
    import fb_div_pkg::*;
#(
    parameter int W              = 4,
    parameter int DEFAULT_N      = 3,
    parameter int SETTLE_PERIODS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         div_en,
    fb_div_ctrl_if.slave cfg,
    output logic [W-1:0] ratio_cur,
    output logic         clk_fb
);

    localparam int SCW = $clog2(SETTLE_PERIODS + 1);

    fb_div_state_e state_q;
    fb_div_state_e state_d;
    logic          run_q;
    logic [W-1:0]  pend_q;
    logic [W-1:0]  pend_d;
    logic [W-1:0]  ratio_q;
    logic [W-1:0]  ratio_d;
    logic [SCW-1:0] settle_q;
    logic [SCW-1:0] settle_d;
    logic          done_q;
    logic          done_d;
    logic          err_q;
    logic          err_d;
    logic          terminal;

    fb_div_core #(
        .W (W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run_q),
        .ratio    (ratio_q),
        .terminal (terminal),
        .clk_fb   (clk_fb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            pend_q   <= W'(DEFAULT_N);
            ratio_q  <= W'(DEFAULT_N);
            settle_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            run_q    <= div_en;
            pend_q   <= pend_d;
            ratio_q  <= ratio_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ratio_d  = ratio_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    if (cfg.cfg_ratio < W'(MIN_N)) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d  = cfg.cfg_ratio;
                        state_d = WAIT_WRAP;
                    end
                end
            end
            WAIT_WRAP: begin
                // Stopped divider has no period edge to wait for.
                if (!run_q || terminal) begin
                    ratio_d  = pend_q;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (terminal) begin
                    if (settle_q == SCW'(SETTLE_PERIODS - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        settle_d = settle_q + SCW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cfg.cfg_ready = (state_q == IDLE);
        cfg.cfg_done  = done_q;
        cfg.cfg_err   = err_q;
        ratio_cur     = ratio_q;
    end

endmodule
